cmp_arbiter: RTL and testbench

- Shares the ALU comparison datapath between two requesters: requester 0 is the branch unit, requester 1 is the SLT/SLTU path.
- Uses round-robin arbitration with valid/ready handshakes on both request ports.
- Has one registered response stage with backpressure.
- Sits between the decode/execute issue logic and the comparison mux; it evaluates the selected comparison and returns an N-bit result tagged with the winning requester.

---
 rtl/cmp_pkg.sv | 20 ++
 rtl/cmp_core.sv | 48 ++++
 rtl/cmp_arbiter.sv | 105 ++++++++++
 tb/tb_cmp_arbiter.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/cmp_pkg.sv
// Shared types for the comparison arbiter: op-code enum and legality helper.
// Codes 0 and 1 are reserved and are reported back as errors.
package cmp_pkg;

    typedef enum logic [2:0] {
        CMP_EQ  = 3'd2,
        CMP_NE  = 3'd3,
        CMP_LT  = 3'd4,
        CMP_GE  = 3'd5,
        CMP_LTU = 3'd6,
        CMP_GEU = 3'd7
    } cmp_op_t;

    localparam int unsigned CMP_OP_W = 3;

    function automatic logic is_legal_cmp_op(input logic [CMP_OP_W-1:0] op);
        return (op >= 3'(CMP_EQ));
    endfunction

endpackage

// File: rtl/cmp_core.sv
// Combinational compare datapath: six flags, zero-extended, picked by a 6:1 mux.
// Illegal op codes give a zero result and raise err.
module cmp_core
    import cmp_pkg::*;
#(
    parameter int unsigned N = 32
) (
    input  logic [CMP_OP_W-1:0] op,
    input  logic [N-1:0]        a,
    input  logic [N-1:0]        b,
    output logic [N-1:0]        result,
    output logic                err
);

    logic eq_f, ne_f, lt_f, ge_f, ltu_f, geu_f;
    logic [N-1:0] eq_x, ne_x, lt_x, ge_x, ltu_x, geu_x;

    always_comb begin
        eq_f  = (a == b);
        ne_f  = !eq_f;
        lt_f  = ($signed(a) < $signed(b));
        ge_f  = !lt_f;
        ltu_f = (a < b);
        geu_f = !ltu_f;
    end

    assign eq_x  = {{(N-1){1'b0}}, eq_f};
    assign ne_x  = {{(N-1){1'b0}}, ne_f};
    assign lt_x  = {{(N-1){1'b0}}, lt_f};
    assign ge_x  = {{(N-1){1'b0}}, ge_f};
    assign ltu_x = {{(N-1){1'b0}}, ltu_f};
    assign geu_x = {{(N-1){1'b0}}, geu_f};

    always_comb begin
        result = '0;
        err    = !is_legal_cmp_op(op);
        case (op)
            CMP_EQ:  result = eq_x;
            CMP_NE:  result = ne_x;
            CMP_LT:  result = lt_x;
            CMP_GE:  result = ge_x;
            CMP_LTU: result = ltu_x;
            CMP_GEU: result = geu_x;
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/cmp_arbiter.sv
// Round-robin arbiter sharing cmp_core between the branch unit (0) and SLT path (1),
// with a single registered response stage that honours rsp_ready backpressure.
module cmp_arbiter
    import cmp_pkg::*;
#(
    parameter int unsigned N = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req0_valid,
    output logic                req0_ready,
    input  logic [CMP_OP_W-1:0] req0_op,
    input  logic [N-1:0]        req0_a,
    input  logic [N-1:0]        req0_b,
    input  logic                req1_valid,
    output logic                req1_ready,
    input  logic [CMP_OP_W-1:0] req1_op,
    input  logic [N-1:0]        req1_a,
    input  logic [N-1:0]        req1_b,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic                rsp_id,
    output logic [N-1:0]        rsp_result,
    output logic                rsp_err
);

    logic          ptr_q, ptr_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic          rsp_id_q, rsp_id_d;
    logic [N-1:0]  rsp_result_q, rsp_result_d;
    logic          rsp_err_q, rsp_err_d;

    logic                can_accept;
    logic                win_id;
    logic                grant;
    logic [CMP_OP_W-1:0] sel_op;
    logic [N-1:0]        sel_a, sel_b;
    logic [N-1:0]        core_result;
    logic                core_err;

    // Pointer only matters on contention; a lone requester always wins.
    always_comb begin
        can_accept = !rsp_valid_q || rsp_ready;
        if (req0_valid && req1_valid) begin
            win_id = ptr_q;
        end else begin
            win_id = req1_valid;
        end
        grant      = can_accept && (req0_valid || req1_valid);
        req0_ready = can_accept && req0_valid && !win_id;
        req1_ready = can_accept && req1_valid && win_id;
        sel_op     = win_id ? req1_op : req0_op;
        sel_a      = win_id ? req1_a  : req0_a;
        sel_b      = win_id ? req1_b  : req0_b;
    end

    cmp_core #(
        .N(N)
    ) u_core (
        .op     (sel_op),
        .a      (sel_a),
        .b      (sel_b),
        .result (core_result),
        .err    (core_err)
    );

    always_comb begin
        ptr_d        = ptr_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_id_d     = rsp_id_q;
        rsp_result_d = rsp_result_q;
        rsp_err_d    = rsp_err_q;
        if (grant) begin
            ptr_d        = !win_id;
            rsp_valid_d  = 1'b1;
            rsp_id_d     = win_id;
            rsp_result_d = core_result;
            rsp_err_d    = core_err;
        end else if (rsp_ready) begin
            rsp_valid_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q        <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_result_q <= '0;
            rsp_err_q    <= 1'b0;
        end else begin
            ptr_q        <= ptr_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_id_q     <= rsp_id_d;
            rsp_result_q <= rsp_result_d;
            rsp_err_q    <= rsp_err_d;
        end
    end

    assign rsp_valid  = rsp_valid_q;
    assign rsp_id     = rsp_id_q;
    assign rsp_result = rsp_result_q;
    assign rsp_err    = rsp_err_q;

endmodule

// File: tb/tb_cmp_arbiter.sv
// Directed bench for cmp_arbiter: accepted requests are predicted into a queue
// and compared against each response as it is drained.
module tb_cmp_arbiter;

    localparam int N = 32;

    typedef struct packed {
        logic          id;
        logic [N-1:0]  res;
        logic          err;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          req0_valid, req0_ready;
    logic [2:0]    req0_op;
    logic [N-1:0]  req0_a, req0_b;
    logic          req1_valid, req1_ready;
    logic [2:0]    req1_op;
    logic [N-1:0]  req1_a, req1_b;
    logic          rsp_valid, rsp_ready, rsp_id, rsp_err;
    logic [N-1:0]  rsp_result;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    cmp_arbiter #(.N(N)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_a(req1_a), .req1_b(req1_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_result(rsp_result), .rsp_err(rsp_err)
    );

    // Reference: signed order obtained by flipping the sign bit, then unsigned compare.
    function automatic exp_t predict(input logic id, input logic [2:0] op,
                                     input logic [N-1:0] a, input logic [N-1:0] b);
        exp_t e;
        logic [N-1:0] sa, sb_;
        logic bit0;
        sa  = a ^ {1'b1, {(N-1){1'b0}}};
        sb_ = b ^ {1'b1, {(N-1){1'b0}}};
        bit0 = 1'b0;
        e.err = 1'b0;
        case (op)
            3'd2: bit0 = (a == b);
            3'd3: bit0 = (a != b);
            3'd4: bit0 = (sa < sb_);
            3'd5: bit0 = (sa >= sb_);
            3'd6: bit0 = (a < b);
            3'd7: bit0 = (a >= b);
            default: e.err = 1'b1;
        endcase
        e.id  = id;
        e.res = {{(N-1){1'b0}}, bit0};
        return e;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v0, input logic [2:0] op0, input logic [N-1:0] a0,
                         input logic [N-1:0] b0, input logic v1, input logic [2:0] op1,
                         input logic [N-1:0] a1, input logic [N-1:0] b1, input logic rr);
        req0_valid = v0; req0_op = op0; req0_a = a0; req0_b = b0;
        req1_valid = v1; req1_op = op1; req1_a = a1; req1_b = b1;
        rsp_ready  = rr;
    endtask

    task automatic idle(input logic rr);
        drive(1'b0, 3'd0, '0, '0, 1'b0, 3'd0, '0, '0, rr);
    endtask

    // Sample at negedge: drain/compare the current response, predict new accepts.
    task automatic tick();
        exp_t e;
        @(negedge clk);
        if (rsp_valid && rsp_ready) begin
            if (sb.size() == 0) begin
                chk("sb_unexpected_rsp", 64'(rsp_id), 64'hDEAD);
            end else begin
                e = sb.pop_front();
                chk("rsp_id", 64'(rsp_id), 64'(e.id));
                chk("rsp_result", 64'(rsp_result), 64'(e.res));
                chk("rsp_err", 64'(rsp_err), 64'(e.err));
            end
        end
        if (req0_valid && req0_ready) sb.push_back(predict(1'b0, req0_op, req0_a, req0_b));
        if (req1_valid && req1_ready) sb.push_back(predict(1'b1, req1_op, req1_a, req1_b));
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        idle(1'b0);
        #2;
        chk("reset_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("reset_rsp_id", 64'(rsp_id), 64'd0);
        chk("reset_rsp_result", 64'(rsp_result), 64'd0);
        chk("reset_rsp_err", 64'(rsp_err), 64'd0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;

        // Single request, EQ on equal operands.
        drive(1'b1, 3'd2, 32'hAA, 32'hAA, 1'b0, 3'd0, '0, '0, 1'b1);
        #1 chk("single_req0_ready", 64'(req0_ready), 64'd1);
        tick();
        idle(1'b1);
        chk("single_rsp_valid", 64'(rsp_valid), 64'd1);
        chk("single_rsp_id", 64'(rsp_id), 64'd0);
        chk("single_rsp_result", 64'(rsp_result), 64'd1);
        tick();

        // Signed vs unsigned on the same operands, back to back.
        drive(1'b0, 3'd0, '0, '0, 1'b1, 3'd4, 32'hFFFF_FFFF, 32'd1, 1'b1);
        tick();
        drive(1'b0, 3'd0, '0, '0, 1'b1, 3'd6, 32'hFFFF_FFFF, 32'd1, 1'b1);
        tick();
        drive(1'b0, 3'd0, '0, '0, 1'b1, 3'd7, 32'hFFFF_FFFF, 32'd1, 1'b1);
        tick();
        drive(1'b0, 3'd0, '0, '0, 1'b1, 3'd5, 32'h8000_0000, 32'h7FFF_FFFF, 1'b1);
        tick();
        idle(1'b1);
        tick();

        // Contention: pointer is 0 after the last requester-1 grant.
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 3'd3, 32'd9, 32'd9, 1'b1, 3'd6, 32'd2, 32'd3, 1'b1);
            #1;
            chk("contend_req0_ready", 64'(req0_ready), 64'((i % 2) == 0));
            chk("contend_req1_ready", 64'(req1_ready), 64'((i % 2) == 1));
            tick();
        end
        idle(1'b1);
        tick();

        // Backpressure: response held while requester 1 waits.
        drive(1'b1, 3'd3, 32'd5, 32'd6, 1'b0, 3'd0, '0, '0, 1'b1);
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 3'd0, '0, '0, 1'b1, 3'd4, 32'd3, 32'd7, 1'b0);
            #1;
            chk("bp_req1_ready", 64'(req1_ready), 64'd0);
            chk("bp_rsp_valid", 64'(rsp_valid), 64'd1);
            chk("bp_rsp_id", 64'(rsp_id), 64'd0);
            chk("bp_rsp_result", 64'(rsp_result), 64'd1);
            chk("bp_rsp_err", 64'(rsp_err), 64'd0);
            tick();
        end
        rsp_ready = 1'b1;
        #1 chk("bp_release_req1_ready", 64'(req1_ready), 64'd1);
        tick();
        idle(1'b1);
        chk("bp_req1_rsp_id", 64'(rsp_id), 64'd1);
        tick();

        // Illegal op consumes a grant and advances the pointer.
        drive(1'b1, 3'd1, 32'd4, 32'd4, 1'b0, 3'd0, '0, '0, 1'b1);
        #1 chk("illegal_req0_ready", 64'(req0_ready), 64'd1);
        tick();
        chk("illegal_rsp_err", 64'(rsp_err), 64'd1);
        chk("illegal_rsp_result", 64'(rsp_result), 64'd0);
        drive(1'b1, 3'd0, 32'd1, 32'd1, 1'b1, 3'd2, 32'd1, 32'd2, 1'b1);
        #1;
        chk("illegal_ptr_req0_ready", 64'(req0_ready), 64'd0);
        chk("illegal_ptr_req1_ready", 64'(req1_ready), 64'd1);
        tick();
        idle(1'b1);
        tick();

        // Reset mid-stall: requester 0 wins, pointer goes to 1, then reset clears both.
        drive(1'b1, 3'd2, 32'd1, 32'd1, 1'b0, 3'd0, '0, '0, 1'b0);
        tick();
        idle(1'b0);
        tick();
        chk("stall_rsp_valid", 64'(rsp_valid), 64'd1);
        rst = 1'b1;
        #1;
        chk("async_rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("async_rst_rsp_err", 64'(rsp_err), 64'd0);
        sb.delete();
        #1 rst = 1'b0;
        drive(1'b1, 3'd5, 32'd8, 32'd3, 1'b1, 3'd7, 32'd3, 32'd8, 1'b1);
        #1;
        chk("post_rst_req0_ready", 64'(req0_ready), 64'd1);
        chk("post_rst_req1_ready", 64'(req1_ready), 64'd0);
        tick();
        tick();
        idle(1'b1);
        tick();
        chk("sb_empty", 64'(sb.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
